block_avg_scanner: RTL and testbench



---
 rtl/block_avg_scanner.sv | 111 +++++++++++
 tb/tb_block_avg_scanner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_avg_scanner.sv
// Walks the frame memory block by block and emits one rounded 8-bit mean per 4x4 block
// over a valid/ready stream (80x60 thumbnail for a 320x240 frame).
//
// state | meaning
// IDLE  | waiting for start, index held at 0
// FETCH | block_addr presented, four block rows captured on the edge
// SUM   | 16-byte sum reduced to a rounded mean, output registers loaded
// OUT   | out_valid high until the consumer accepts
// DONE  | one-cycle done pulse, index cleared
module block_avg_scanner #(
    parameter int BLOCKS_PER_ROW = 80,
    parameter int BLOCK_ROWS     = 60,
    parameter int ADDR_W         = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] block_addr,
    input  logic [31:0]       row0,
    input  logic [31:0]       row1,
    input  logic [31:0]       row2,
    input  logic [31:0]       row3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_pix,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int NUM_BLOCKS = BLOCKS_PER_ROW * BLOCK_ROWS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SUM, OUT, DONE} stateT;

    stateT             state;
    stateT             stateNext;
    logic [ADDR_W-1:0] blockIdx;
    logic [127:0]      blockReg;
    logic [11:0]       blockSum;
    logic [7:0]        blockMean;

    // The memory address is the index itself: it only moves on the handshake that
    // re-enters FETCH, and returns to 0 in DONE so IDLE always shows block 0.
    assign block_addr = blockIdx;

    always_comb begin
        blockSum = '0;
        for (int i = 0; i < 16; i++) begin
            blockSum = blockSum + 12'(blockReg[i*8 +: 8]);
        end
        blockMean = 8'((blockSum + 12'd8) >> 4);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = FETCH;
            FETCH:   stateNext = SUM;
            SUM:     stateNext = OUT;
            OUT:     if (out_ready) stateNext = out_last ? DONE : FETCH;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= (stateNext == OUT);
            busy      <= (stateNext != IDLE);
            done      <= (stateNext == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blockIdx <= '0;
            blockReg <= '0;
            out_pix  <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                FETCH: blockReg <= {row0, row1, row2, row3};
                SUM: begin
                    out_pix  <= blockMean;
                    out_addr <= blockIdx;
                    out_last <= (blockIdx == LAST_IDX);
                end
                OUT:     if (out_ready && !out_last) blockIdx <= blockIdx + 1'b1;
                DONE:    blockIdx <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_avg_scanner.sv
// Scoreboard bench for block_avg_scanner: a frame-memory model feeds the DUT, expected
// means are computed from the frame pixels and checked by an independent monitor.
module tb_block_avg_scanner;

    localparam int NB = 4800;
    localparam int FW = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [12:0] block_addr;
    logic [31:0] row0, row1, row2, row3;
    logic        out_valid;
    logic [7:0]  out_pix;
    logic [12:0] out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    block_avg_scanner dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block_addr(block_addr),
        .row0(row0), .row1(row1), .row2(row2), .row3(row3),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] frame [0:76799];

    function automatic logic [31:0] rowWord(input logic [12:0] a, input int r);
        int bx, by, base;
        bx = int'(a) % 80;
        by = int'(a) / 80;
        base = (by * 4 + r) * FW + bx * 4;
        return {frame[base], frame[base+1], frame[base+2], frame[base+3]};
    endfunction

    // Memory read window: rows settle mid-cycle, ahead of the FETCH capture edge.
    always @(negedge clk) begin
        row0 = rowWord(block_addr, 0);
        row1 = rowWord(block_addr, 1);
        row2 = rowWord(block_addr, 2);
        row3 = rowWord(block_addr, 3);
    end

    function automatic logic [7:0] refMean(input int b);
        int sum;
        sum = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                sum += int'(frame[((b / 80) * 4 + y) * FW + (b % 80) * 4 + x]);
        return 8'((sum + 8) / 16);
    endfunction

    typedef struct {
        logic [7:0]  pix;
        logic [12:0] addr;
        logic        last;
    } expT;

    expT sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    int readyMode = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    bit          prevStall = 0;
    bit          prevDone = 0;
    logic [7:0]  hPix;
    logic [12:0] hAddr, hBa;
    logic        hLast;
    int          stallRun = 0;
    int          stallMax = 0;
    int          doneCount = 0;
    logic [7:0]  capPix [0:2];

    always @(negedge clk) begin
        expT e;
        if (!rst_n) begin
            prevStall = 0;
            prevDone = 0;
            stallRun = 0;
        end else begin
            if (prevStall) begin
                chk("valid_held", out_valid, 1);
                if (out_valid) begin
                    chk("pix_held", out_pix, hPix);
                    chk("addr_held", out_addr, hAddr);
                    chk("last_held", out_last, hLast);
                    chk("blockaddr_held", block_addr, hBa);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("out_pix", out_pix, e.pix);
                    chk("out_addr", out_addr, e.addr);
                    chk("out_last", out_last, e.last);
                    if (out_addr < 3) capPix[out_addr] = out_pix;
                end
            end
            prevStall = out_valid && !out_ready;
            if (prevStall) begin
                hPix = out_pix; hAddr = out_addr; hLast = out_last; hBa = block_addr;
                stallRun++;
                if (stallRun > stallMax) stallMax = stallRun;
            end else begin
                stallRun = 0;
            end
            if (done) begin
                doneCount++;
                chk("done_width", prevDone, 0);
            end
            prevDone = done;
        end
    end

    task automatic pushFrame();
        for (int b = 0; b < NB; b++) sb.push_back('{refMean(b), 13'(b), b == NB - 1});
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs one full frame; cyc counts clock edges from the start-sampling edge to done.
    task automatic runScan(input bit pulseBusy, input bit bp, output int cyc);
        pushFrame();
        pulseStart();
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (cyc == 2) chk("valid_at_n2", out_valid, 0);
            if (cyc == 3) chk("valid_at_n3", out_valid, 1);
            if (done) break;
            if (cyc > 60000) begin
                chk("done_timeout", cyc, 60000);
                break;
            end
            @(posedge clk); #1;
            start = pulseBusy && (cyc % 1000 == 500);
            if (bp && cyc == 9) readyMode = 1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic checkResetValues();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_block_addr", block_addr, 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 76800; i++) frame[i] = 8'h80;
        #3 checkResetValues();
        #20;
        @(posedge clk); #1 rst_n = 1'b1;

        // Flat 0x80 frame, consumer always ready.
        readyMode = 0;
        doneCount = 0;
        runScan(0, 0, cyc);
        repeat (3) @(negedge clk);
        chk("done_latency", cyc, 14401);
        chk("done_count_flat", doneCount, 1);
        chk("sb_empty_flat", sb.size(), 0);
        chk("idle_busy_flat", busy, 0);
        chk("idle_blockaddr", block_addr, 0);

        // Random frame with hand-placed blocks, random backpressure, start pulsed while busy.
        for (int i = 0; i < 76800; i++) frame[i] = 8'($urandom_range(0, 255));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                frame[r * FW + c]     = 8'(r * 4 + c);
                frame[r * FW + 4 + c] = 8'hFF;
                frame[r * FW + 8 + c] = 8'((r * 4 + c) % 2);
            end
        readyMode = 2;
        stallMax = 0;
        doneCount = 0;
        runScan(1, 1, cyc);
        repeat (5) @(negedge clk);
        chk("block0_mean", capPix[0], 8'h08);
        chk("block1_mean", capPix[1], 8'hFF);
        chk("block2_mean", capPix[2], 8'h01);
        chk("done_count_busy_start", doneCount, 1);
        chk("sb_empty_rand", sb.size(), 0);
        chk("stall_at_least_5", 32'(stallMax >= 5), 1);
        chk("no_restart_busy", busy, 0);
        chk("no_restart_valid", out_valid, 0);

        // Reset in the middle of a frame, then a clean rescan.
        readyMode = 0;
        pushFrame();
        pulseStart();
        cyc = 0;
        while (block_addr != 13'd1000 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_block_1000", block_addr, 1000);
        #2 rst_n = 1'b0;
        #1 checkResetValues();
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkResetValues();
        doneCount = 0;
        runScan(0, 0, cyc);
        repeat (3) @(negedge clk);
        chk("done_latency_rescan", cyc, 14401);
        chk("done_count_rescan", doneCount, 1);
        chk("sb_empty_rescan", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
